ga_palette_regs: RTL and testbench

Parametrised gate-array register bank: decodes Z80 writes to the gate-array I/O port and holds the pen select, border colour, palette, screen mode, ROM enables and IRQ-reset strobe. It extends the basic register block in four ways: generic pen count and colour width, one-shot write strobes, optional pen auto-increment, and HSYNC-deferred commit of palette and mode. It sits between the CPU bus decode and the video pixel/colour pipeline.

---
 rtl/ga_palette_regs.sv | 100 ++++++++++
 tb/tb_ga_palette_regs.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ga_palette_regs.sv
// ga_palette_regs: gate-array I/O register bank with pen/border/palette, mode, ROM enables and HSYNC-deferred commit
module ga_palette_regs #(
  parameter int         PENS       = 16,
  parameter int         COLOUR_W   = 5,
  parameter logic [4:0] BORDER_RST = 5'h10,
  parameter bit         EXT_CTRL   = 1'b0
) (
  input  logic                     CLK_n,
  input  logic                     RESET,
  input  logic                     M1_n,
  input  logic                     A14,
  input  logic                     A15,
  input  logic                     IORQ_n,
  input  logic                     S0,
  input  logic                     S7,
  input  logic [7:0]               D,
  input  logic                     HSYNC,
  output logic [COLOUR_W-1:0]      BORDER,
  output logic [PENS*COLOUR_W-1:0] INK,
  output logic [1:0]               MODE,
  output logic                     HROMEN,
  output logic                     LROMEN,
  output logic                     IRQ_RESET,
  output logic                     PAL_PENDING
);
  localparam int PEN_W = PENS > 1 ? $clog2(PENS) : 1;
  localparam logic [3:0] LAST = 4'(PENS - 1);
  logic sel, sel_d, wr, hsync_d, hs_rise, bsel, autoinc, defer, pen_ok, cwr, unused;
  logic [3:0] pen;
  logic [PEN_W-1:0] pen_i;
  logic [1:0] mode_pend;
  logic [COLOUR_W-1:0] colour;
  logic [COLOUR_W-1:0] live [PENS];
  logic [COLOUR_W-1:0] shadow [PENS];
  logic [PENS-1:0] dirty, dirty_n;
  always_comb begin
    sel = M1_n & A14 & ~A15 & ~IORQ_n & S0 & S7;
    wr = sel & ~sel_d;
    hs_rise = HSYNC & ~hsync_d;
    colour = D[COLOUR_W-1:0];
    pen_ok = pen <= LAST;
    pen_i = pen[PEN_W-1:0];
    cwr = wr && D[7:6] == 2'b01 && !bsel;
    IRQ_RESET = wr && !RESET && D[7:6] == 2'b10 && D[4];
    unused = D[5];
    dirty_n = hs_rise ? '0 : dirty;
    if (cwr && pen_ok) dirty_n[pen_i] = defer;
  end
  // pen is kept 4 bits wide so out-of-range selects can be detected and ignored
  always_ff @(posedge CLK_n) begin
    sel_d <= sel;
    if (RESET) begin
      BORDER <= BORDER_RST[COLOUR_W-1:0];
      for (int n = 0; n < PENS; n++) begin
        live[n] <= '0;
        shadow[n] <= '0;
      end
      dirty <= '0;
      PAL_PENDING <= 1'b0;
      MODE <= 2'd0;
      mode_pend <= 2'd0;
      HROMEN <= 1'b0;
      LROMEN <= 1'b0;
      pen <= 4'd0;
      bsel <= 1'b0;
      autoinc <= 1'b0;
      defer <= 1'b0;
      hsync_d <= 1'b0;
    end else begin
      hsync_d <= HSYNC;
      dirty <= dirty_n;
      PAL_PENDING <= |dirty_n;
      if (hs_rise) MODE <= mode_pend;
      for (int n = 0; n < PENS; n++)
        if (hs_rise && dirty[n]) live[n] <= shadow[n];
      if (cwr && pen_ok) begin
        shadow[pen_i] <= colour;
        if (!defer) live[pen_i] <= colour;
      end
      if (cwr && autoinc) pen <= pen >= LAST ? 4'd0 : pen + 4'd1;
      if (wr && D[7:6] == 2'b00) begin
        bsel <= D[4];
        pen <= D[3:0];
      end
      if (wr && D[7:6] == 2'b01 && bsel) BORDER <= colour;
      if (wr && D[7:6] == 2'b10) begin
        mode_pend <= D[1:0];
        LROMEN <= D[2];
        HROMEN <= D[3];
      end
      if (EXT_CTRL && wr && D[7:6] == 2'b11) begin
        autoinc <= D[0];
        defer <= D[1];
      end
    end
  end
  for (genvar i = 0; i < PENS; i++) begin : g_ink
    assign INK[i*COLOUR_W +: COLOUR_W] = live[i];
  end
endmodule

// File: tb/tb_ga_palette_regs.sv
// tb_ga_palette_regs: randomized check of two ga_palette_regs configurations against a reference model
module tb_ga_palette_regs;
  localparam logic [5:0] PAT = 6'b110011;
  logic CLK_n = 1'b0, RESET, M1_n, A14, A15, IORQ_n, S0, S7, HSYNC;
  logic [7:0] D;
  logic [4:0] b0;
  logic [3:0] b1;
  logic [79:0] ink0;
  logic [15:0] ink1;
  logic [1:0] m0, m1;
  logic hr0, lr0, irq0, pp0, hr1, lr1, irq1, pp1;
  int n_chk = 0, n_err = 0;
  int P[2] = '{16, 4};
  int CW[2] = '{5, 4};
  bit EX[2] = '{1'b1, 1'b0};
  int live[2][16], shadow[2][16], border[2], mode[2], mpend[2], pen[2];
  bit dirty[2][16];
  bit bsel[2], hr[2], lr[2], ai[2], df[2];
  bit msd = 1'b0, mhd = 1'b0;

  always #5 CLK_n = ~CLK_n;

  ga_palette_regs #(.PENS(16), .COLOUR_W(5), .BORDER_RST(5'h10), .EXT_CTRL(1'b1)) u0 (
    .CLK_n(CLK_n), .RESET(RESET), .M1_n(M1_n), .A14(A14), .A15(A15), .IORQ_n(IORQ_n),
    .S0(S0), .S7(S7), .D(D), .HSYNC(HSYNC), .BORDER(b0), .INK(ink0), .MODE(m0),
    .HROMEN(hr0), .LROMEN(lr0), .IRQ_RESET(irq0), .PAL_PENDING(pp0));
  ga_palette_regs #(.PENS(4), .COLOUR_W(4), .BORDER_RST(5'h10), .EXT_CTRL(1'b0)) u1 (
    .CLK_n(CLK_n), .RESET(RESET), .M1_n(M1_n), .A14(A14), .A15(A15), .IORQ_n(IORQ_n),
    .S0(S0), .S7(S7), .D(D), .HSYNC(HSYNC), .BORDER(b1), .INK(ink1), .MODE(m1),
    .HROMEN(hr1), .LROMEN(lr1), .IRQ_RESET(irq1), .PAL_PENDING(pp1));

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit s, input logic [7:0] d, input bit hs, input bit r);
    bit wr, com;
    int c;
    wr = s && !msd;
    com = hs && !mhd;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        border[k] = 16 & ((1 << CW[k]) - 1);
        mode[k] = 0; mpend[k] = 0; pen[k] = 0;
        bsel[k] = 0; hr[k] = 0; lr[k] = 0; ai[k] = 0; df[k] = 0;
        for (int n = 0; n < 16; n++) begin
          live[k][n] = 0; shadow[k][n] = 0; dirty[k][n] = 0;
        end
      end else begin
        if (com) begin
          mode[k] = mpend[k];
          for (int n = 0; n < P[k]; n++)
            if (dirty[k][n]) begin
              live[k][n] = shadow[k][n];
              dirty[k][n] = 0;
            end
        end
        if (wr) begin
          c = int'(d) & ((1 << CW[k]) - 1);
          case (d[7:6])
            2'b00: begin bsel[k] = d[4]; pen[k] = int'(d[3:0]); end
            2'b01:
              if (bsel[k]) border[k] = c;
              else begin
                if (pen[k] < P[k]) begin
                  shadow[k][pen[k]] = c;
                  if (df[k]) dirty[k][pen[k]] = 1;
                  else begin live[k][pen[k]] = c; dirty[k][pen[k]] = 0; end
                end
                if (ai[k]) pen[k] = pen[k] >= P[k] - 1 ? 0 : pen[k] + 1;
              end
            2'b10: begin mpend[k] = int'(d[1:0]); lr[k] = d[2]; hr[k] = d[3]; end
            default: if (EX[k]) begin ai[k] = d[0]; df[k] = d[1]; end
          endcase
        end
      end
    end
    msd = s;
    mhd = r ? 1'b0 : hs;
  endtask

  task automatic check_all(input int k);
    logic [79:0] ink;
    bit pp;
    string t;
    t = k == 0 ? "u0." : "u1.";
    ink = '0;
    pp = 0;
    for (int n = 0; n < P[k]; n++) begin
      ink = ink | (80'(live[k][n]) << (n * CW[k]));
      pp = pp | dirty[k][n];
    end
    chk({t, "border"}, k == 0 ? 80'(b0) : 80'(b1), 80'(border[k]));
    chk({t, "ink"}, k == 0 ? ink0 : 80'(ink1), ink);
    chk({t, "mode"}, k == 0 ? 80'(m0) : 80'(m1), 80'(mode[k]));
    chk({t, "hromen"}, k == 0 ? 80'(hr0) : 80'(hr1), 80'(hr[k]));
    chk({t, "lromen"}, k == 0 ? 80'(lr0) : 80'(lr1), 80'(lr[k]));
    chk({t, "pal_pending"}, k == 0 ? 80'(pp0) : 80'(pp1), 80'(pp));
  endtask

  task automatic cyc(input bit s, input logic [7:0] d, input bit hs, input bit r);
    logic [5:0] q;
    bit irq;
    q = s ? PAT : 6'($urandom);
    if (!s && q == PAT) q[0] = ~q[0];
    {M1_n, A14, A15, IORQ_n, S0, S7} = q;
    D = d;
    HSYNC = hs;
    RESET = r;
    #1;
    irq = !r && s && !msd && d[7:6] == 2'b10 && d[4];
    chk("u0.irq_reset", 80'(irq0), 80'(irq));
    chk("u1.irq_reset", 80'(irq1), 80'(irq));
    @(posedge CLK_n);
    model(s, d, hs, r);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic wrb(input logic [7:0] d);
    cyc(1, d, 0, 0);
    cyc(0, d, 0, 0);
  endtask

  task automatic hsr();
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
  endtask

  initial begin
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    wrb(8'h00);
    repeat (4) cyc(1, 8'h4B, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("pen0_first", 80'(ink0[4:0]), 80'h0B);
    wrb(8'hC1);
    wrb(8'h0E);
    wrb(8'h41);
    wrb(8'h42);
    wrb(8'h43);
    wrb(8'h44);
    chk("pen14_inc", 80'(ink0[74:70]), 80'h01);
    chk("pen15_inc", 80'(ink0[79:75]), 80'h02);
    chk("pen0_wrap", 80'(ink0[4:0]), 80'h03);
    chk("pen1_after", 80'(ink0[9:5]), 80'h04);
    wrb(8'hC2);
    wrb(8'h03);
    wrb(8'h55);
    chk("pen3_deferred", 80'(ink0[19:15]), 80'h00);
    chk("pending_set", 80'(pp0), 80'h1);
    hsr();
    chk("pen3_commit", 80'(ink0[19:15]), 80'h15);
    chk("pending_clear", 80'(pp0), 80'h0);
    wrb(8'h8D);
    chk("mode_pending", 80'(m0), 80'h0);
    hsr();
    chk("mode_commit", 80'(m0), 80'h1);
    wrb(8'h90);
    wrb(8'h02);
    wrb(8'h49);
    hsr();
    cyc(1, 8'h47, 1, 0);
    cyc(0, 8'h00, 0, 0);
    chk("pen2_same_edge", 80'(ink0[14:10]), 80'h09);
    chk("pen2_dirty", 80'(pp0), 80'h1);
    hsr();
    chk("pen2_next_commit", 80'(ink0[14:10]), 80'h07);
    wrb(8'h09);
    wrb(8'h5F);
    wrb(8'h10);
    wrb(8'h5F);
    chk("u1_border", 80'(b1), 80'hF);
    cyc(1, 8'h8C, 0, 1);
    cyc(1, 8'h8C, 0, 1);
    cyc(1, 8'h8C, 0, 0);
    cyc(1, 8'h8C, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("reset_no_write", 80'(lr0), 80'h0);
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      cyc(bit'($urandom_range(0, 1)), d, $urandom_range(0, 5) < 2, $urandom_range(0, 299) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
